sseg_display_capture: RTL

//  Receive-side counterpart of the 4-digit time-multiplexed 7-segment driver. It samples the

---
 rtl/sseg_pkg.sv | 79 +++++++
 rtl/sseg_pattern_decode.sv | 28 ++
 rtl/sseg_display_capture.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared 7-segment definitions: segment patterns, anode codes and digit indexing.
// Both the display driver and the capture checker use this package so their tables stay identical.
package sseg_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned AN_W       = 4;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned NUM_DIGITS = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a} reversed: [6:0] = a..g
    localparam logic [SEG_W-1:0] SSEG_0 = 7'h01;
    localparam logic [SEG_W-1:0] SSEG_1 = 7'h4F;
    localparam logic [SEG_W-1:0] SSEG_2 = 7'h12;
    localparam logic [SEG_W-1:0] SSEG_3 = 7'h06;
    localparam logic [SEG_W-1:0] SSEG_4 = 7'h4C;
    localparam logic [SEG_W-1:0] SSEG_5 = 7'h24;
    localparam logic [SEG_W-1:0] SSEG_6 = 7'h20;
    localparam logic [SEG_W-1:0] SSEG_7 = 7'h0F;
    localparam logic [SEG_W-1:0] SSEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SSEG_9 = 7'h04;
    localparam logic [SEG_W-1:0] SSEG_F = 7'h38;

    localparam logic [AN_W-1:0] SSEG_BLANK_AN = 4'b1111;

    typedef enum logic [1:0] {
        DIGIT0 = 2'd0,
        DIGIT1 = 2'd1,
        DIGIT2 = 2'd2,
        DIGIT3 = 2'd3
    } digit_idx_e;

    typedef enum logic {
        WIN_WAIT = 1'b0,
        WIN_DONE = 1'b1
    } win_state_e;

    typedef struct packed {
        logic              valid;
        logic [CODE_W-1:0] code;
    } decode_t;

    typedef struct packed {
        logic       valid;
        digit_idx_e idx;
    } an_map_t;

    typedef struct packed {
        logic [AN_W-1:0]  an;
        logic [SEG_W-1:0] seg;
    } sample_t;

    // Anode enable (one-hot-low) to digit index; blank or multi-lit codes are not valid.
    function automatic an_map_t an_to_idx(input logic [AN_W-1:0] an);
        an_map_t m;
        m.valid = 1'b1;
        m.idx   = DIGIT0;
        case (an)
            4'b1110: m.idx = DIGIT0;
            4'b1101: m.idx = DIGIT1;
            4'b1011: m.idx = DIGIT2;
            4'b0111: m.idx = DIGIT3;
            default: m.valid = 1'b0;
        endcase
        return m;
    endfunction

    // Digit index to anode enable, the inverse mapping used by the driver side.
    function automatic logic [AN_W-1:0] idx_to_an(input digit_idx_e idx);
        logic [AN_W-1:0] an;
        case (idx)
            DIGIT0:  an = 4'b1110;
            DIGIT1:  an = 4'b1101;
            DIGIT2:  an = 4'b1011;
            default: an = 4'b0111;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational 7-segment pattern to 4-bit code decoder; unknown patterns report valid=0.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output decode_t          result_c
);

    always_comb begin
        result_c.valid = 1'b1;
        result_c.code  = CODE_W'(0);
        case (pattern)
            SSEG_0:  result_c.code = 4'h0;
            SSEG_1:  result_c.code = 4'h1;
            SSEG_2:  result_c.code = 4'h2;
            SSEG_3:  result_c.code = 4'h3;
            SSEG_4:  result_c.code = 4'h4;
            SSEG_5:  result_c.code = 4'h5;
            SSEG_6:  result_c.code = 4'h6;
            SSEG_7:  result_c.code = 4'h7;
            SSEG_8:  result_c.code = 4'h8;
            SSEG_9:  result_c.code = 4'h9;
            SSEG_F:  result_c.code = 4'hF;
            default: result_c.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_display_capture.sv
// Samples a multiplexed 7-segment bus, waits for each digit window to settle,
// and rebuilds the four displayed codes with frame, error and staleness reporting.
module sseg_display_capture
    import sseg_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 524288
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AN_W-1:0]       an_in,
    input  logic [7:0]            sseg_in,
    output logic [CODE_W-1:0]     d0,
    output logic [CODE_W-1:0]     d1,
    output logic [CODE_W-1:0]     d2,
    output logic [CODE_W-1:0]     d3,
    output logic [NUM_DIGITS-1:0] digit_err,
    output logic                  frame_valid,
    output logic                  stale
);

    localparam int unsigned STAB_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

    sample_t sample_c;
    sample_t sync1_q, sync1_d;
    sample_t sync2_q, sync2_d;
    sample_t prev_q,  prev_d;
    logic    changed_c;

    logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;

    win_state_e state_q, state_d;
    logic       capture_c;

    an_map_t    an_map_c;
    logic [1:0] cap_idx_c;
    decode_t    dec_c;

    logic [NUM_DIGITS-1:0][CODE_W-1:0] digit_q, digit_d;
    logic [NUM_DIGITS-1:0]             err_q, err_d;
    logic [NUM_DIGITS-1:0]             mask_q, mask_d;
    logic                              frame_q, frame_d;
    logic [IDLE_W-1:0]                 idle_cnt_q, idle_cnt_d;
    logic                              stale_q, stale_d;

    // Decimal point carries no digit information.
    logic unused_dp;
    assign unused_dp = sseg_in[7];

    assign sample_c = {an_in, sseg_in[SEG_W-1:0]};

    // Synchronizer, change detection and settle counter.
    always_comb begin
        sync1_d   = sample_c;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        changed_c = (sync2_q != prev_q);
        if (changed_c) begin
            stab_cnt_d = STAB_W'(0);
        end else if (stab_cnt_q == STAB_MAX) begin
            stab_cnt_d = stab_cnt_q;
        end else begin
            stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
    end

    assign an_map_c  = an_to_idx(sync2_q.an);
    assign cap_idx_c = an_map_c.idx;

    sseg_pattern_decode u_decode (
        .pattern  (sync2_q.seg),
        .result_c (dec_c)
    );

    // Window FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WIN_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Window FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WIN_WAIT: if (capture_c) state_d = WIN_DONE;
            WIN_DONE: if (changed_c) state_d = WIN_WAIT;
        endcase
    end

    // Window FSM: one capture per settled window with a single lit anode.
    always_comb begin
        capture_c = 1'b0;
        if ((state_q == WIN_WAIT) && (stab_cnt_d == STAB_MAX) && an_map_c.valid) begin
            capture_c = 1'b1;
        end
    end

    // Capture registers, frame mask and idle timeout.
    always_comb begin
        digit_d    = digit_q;
        err_d      = err_q;
        mask_d     = mask_q;
        frame_d    = 1'b0;
        idle_cnt_d = idle_cnt_q;
        stale_d    = stale_q;
        if (capture_c) begin
            if (dec_c.valid) begin
                digit_d[cap_idx_c] = dec_c.code;
                err_d[cap_idx_c]   = 1'b0;
            end else begin
                err_d[cap_idx_c]   = 1'b1;
            end
            mask_d = mask_q | (NUM_DIGITS'(1) << cap_idx_c);
            if (mask_d == {NUM_DIGITS{1'b1}}) begin
                frame_d = 1'b1;
                mask_d  = '0;
            end
            idle_cnt_d = IDLE_W'(0);
            stale_d    = 1'b0;
        end else begin
            if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
            stale_d = (idle_cnt_d == IDLE_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            stab_cnt_q <= '0;
            digit_q    <= '0;
            err_q      <= '0;
            mask_q     <= '0;
            frame_q    <= 1'b0;
            idle_cnt_q <= '0;
            stale_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            stab_cnt_q <= stab_cnt_d;
            digit_q    <= digit_d;
            err_q      <= err_d;
            mask_q     <= mask_d;
            frame_q    <= frame_d;
            idle_cnt_q <= idle_cnt_d;
            stale_q    <= stale_d;
        end
    end

    assign d0          = digit_q[0];
    assign d1          = digit_q[1];
    assign d2          = digit_q[2];
    assign d3          = digit_q[3];
    assign digit_err   = err_q;
    assign frame_valid = frame_q;
    assign stale       = stale_q;

endmodule
